puf_soc_chal_ctrl: RTL
======================

# puf_soc_chal_ctrl

Challenge-load controller for the PUF SoC. Sequences a variable-length serial challenge stream into fixed N_BIT parallel words, zero-pads the final partial word, and hands each word to the PUF challenge register over a valid/ready handshake. Sits between the serial receive front end and the PUF core's challenge input; owns all framing, padding and abort decisions.

## Interface
- N_BIT, 32, parallel word width.
- N_WORDS, 4, maximum words per challenge.
- LEN_W, 8, width of i_len; must satisfy 2**LEN_W > N_BIT*N_WORDS.
- TIMEOUT_CYC, 1024, idle-cycle limit in SHIFT; used only with PUF_SOC_CHAL_CTRL_TIMEOUT_EN.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- i_start  in  1  begin a challenge load; sampled in IDLE only.
- i_len  in  LEN_W  valid serial bit count, latched with i_start.
- i_ser_valid  in  1  serial bit valid.
- i_ser_data  in  1  serial bit.
- o_ser_ready  out  1  controller accepts a serial bit this cycle.
- o_word_valid  out  1  o_word_data holds a completed word.
- o_word_data  out  N_BIT  completed word; first received bit at bit 0.
- i_word_ready  in  1  downstream accepts the word.
- o_busy  out  1  high in any state except IDLE.
- o_done  out  1  one-cycle pulse on a completed load.
- o_err  out  1  one-cycle pulse on a rejected or aborted load.

## Operation
- States: IDLE, SHIFT, PAD, PUSH, DONE.
- IDLE: i_start with 1 <= i_len <= N_BIT*N_WORDS latches i_len, clears the bit and word counters, and moves to SHIFT. i_start with i_len out of range pulses o_err and stays in IDLE.
- SHIFT: o_ser_ready=1. Each cycle with i_ser_valid & o_ser_ready shifts i_ser_data into the MSB, shifting right, and increments the bit-in-word and total counters.
  - If the word counter reaches N_BIT: go to PUSH.
  - Else if the total reaches the latched length: go to PAD.
- PAD: o_ser_ready=0. Shifts one zero per cycle until the word counter reaches N_BIT, then goes to PUSH. This places the first bit at bit 0 and zeros in the high bits.
- PUSH: o_word_valid=1. o_word_data is held stable until i_word_ready is seen.
  - On handshake, if total == length: go to DONE.
  - Otherwise clear the word counter and return to SHIFT.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Words pushed per load = ceil(len/N_BIT). Unused word slots are never emitted.
- i_start outside IDLE is ignored. i_ser_valid outside SHIFT is ignored, with no data loss to the controller because ready is low.
- Counters: bit-in-word counter is $clog2(N_BIT)+1 bits; total counter is LEN_W bits. Neither counter wraps within a legal load.

## Timing
- Reset values: o_ser_ready=0, o_word_valid=0, o_word_data=0, o_busy=0, o_done=0, o_err=0, state=IDLE, all counters 0.
- i_start to first o_ser_ready: 1 cycle.
- Last accepted bit of a full word to o_word_valid: 1 cycle.
- Short final word: o_word_valid rises (N_BIT - bits_in_word) + 1 cycles after the last bit.
- Handshake on the final word to o_done: 1 cycle. o_done to o_busy=0: same cycle o_done falls.
- o_err pulses the cycle after an illegal i_start.
- rst_n asserted mid-load: immediate return to reset values. A partial word is discarded, never emitted.
- o_word_data changes only on entry to PUSH and is not cleared on exit.

## Configuration
- PUF_SOC_CHAL_CTRL_TIMEOUT_EN defined: a watchdog counts consecutive SHIFT cycles without an accepted bit. When the count reaches TIMEOUT_CYC, the controller pulses o_err, discards the partial word and goes to IDLE. The watchdog clears on every accepted bit.
- Macro undefined: no watchdog logic; SHIFT waits indefinitely.

## Structure
- puf_soc_pkg holds the state enum (IDLE/SHIFT/PAD/PUSH/DONE) and the default N_BIT/N_WORDS constants.
- One sub-module: puf_soc_chal_shreg. It contains the N_BIT shift register, the bit-in-word counter and the full flag, with shift-enable and shift-bit inputs, so SHIFT and PAD drive the same datapath.
- The FSM, total counter, handshake and watchdog live in puf_soc_chal_ctrl.

## Test plan
- len=32, 32 bits of 0xA5A5_5A5A sent LSB first, ready held high -> one word 0xA5A5_5A5A, then o_done; o_err never asserted.
- len=40, bits = 0xFFFF_FFFF then 8 ones -> words 0xFFFF_FFFF and 0x0000_00FF; 24 PAD cycles before the second o_word_valid.
- len=0 and len=129 at N_WORDS=4 -> o_err pulse only, o_busy stays 0, o_ser_ready stays 0.
- i_word_ready held low 10 cycles in PUSH -> o_word_valid and data stable for 10 cycles; o_ser_ready=0 throughout; i_start ignored.
- rst_n dropped after 17 bits, then a fresh len=8 load of 0x3C -> single word 0x0000_003C with no residue from the aborted load.
- With TIMEOUT_EN and TIMEOUT_CYC=16: stall i_ser_valid after 5 bits -> o_err exactly 16 cycles later, then IDLE. Without the macro, the same stall leaves the controller in SHIFT.

Source files
------------

// File: rtl/puf_soc_pkg.sv
// puf_soc_pkg: shared types and default sizing for the PUF SoC challenge path.
package puf_soc_pkg;

    localparam int unsigned N_BIT_DEF   = 32;
    localparam int unsigned N_WORDS_DEF = 4;
    localparam int unsigned LEN_W_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PAD,
        ST_PUSH,
        ST_DONE
    } chal_state_e;

endpackage

// File: rtl/puf_soc_chal_shreg.sv
// puf_soc_chal_shreg: N_BIT right-shifting word register with a bit-in-word
// counter. Real serial bits and padding zeros both enter through the same
// shift port. The next-state word and the next-state full flag are exported
// so the controller can capture a completed word on the very edge that fills it.
module puf_soc_chal_shreg
    import puf_soc_pkg::*;
#(
    parameter int unsigned N_BIT = N_BIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             shift_en_i,
    input  logic             shift_bit_i,
    output logic [N_BIT-1:0] data_d_o,
    output logic             full_d_o
);

    localparam int unsigned     CW       = $clog2(N_BIT) + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(N_BIT);

    logic [N_BIT-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Next-state datapath: clear wins over shift; new bits enter at the MSB.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (shift_en_i) begin
            data_d = {shift_bit_i, data_q[N_BIT-1:1]};
            cnt_d  = cnt_q + CW'(1);
        end
    end

    // Word and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_d_o = data_d;
    assign full_d_o = (cnt_d == FULL_CNT);

endmodule

// File: rtl/puf_soc_chal_ctrl.sv
// puf_soc_chal_ctrl: frames a variable-length serial challenge into N_BIT
// words, zero-pads the final partial word and pushes each word downstream
// over a valid/ready handshake.
// Optional SHIFT idle watchdog: define PUF_SOC_CHAL_CTRL_TIMEOUT_EN.
module puf_soc_chal_ctrl
    import puf_soc_pkg::*;
#(
    parameter int unsigned N_BIT       = N_BIT_DEF,
    parameter int unsigned N_WORDS     = N_WORDS_DEF,
`ifdef PUF_SOC_CHAL_CTRL_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYC = 1024,
`endif
    parameter int unsigned LEN_W       = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_ser_valid,
    input  logic             i_ser_data,
    output logic             o_ser_ready,
    output logic             o_word_valid,
    output logic [N_BIT-1:0] o_word_data,
    input  logic             i_word_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(N_BIT * N_WORDS);

    chal_state_e      state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] tot_q, tot_d;
    logic             ready_q, valid_q, busy_q, done_q, err_q;
    logic [N_BIT-1:0] word_q;

    logic             accept;
    logic             len_ok;
    logic             sh_clear, sh_en, sh_bit;
    logic [N_BIT-1:0] sh_data;
    logic             sh_full;

`ifdef PUF_SOC_CHAL_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;
`endif

    assign accept = (state_q == ST_SHIFT) && i_ser_valid;
    assign tot_d  = tot_q + LEN_W'(1);
    assign len_ok = (i_len != '0) && ({1'b0, i_len} <= MAX_LEN);

    // Shift register control: real bits in SHIFT, zeros in PAD, held clear while idle.
    always_comb begin
        sh_clear = (state_q == ST_IDLE) || ((state_q == ST_PUSH) && i_word_ready);
        sh_en    = accept || (state_q == ST_PAD);
        sh_bit   = (state_q == ST_SHIFT) && i_ser_data;
    end

    puf_soc_chal_shreg #(
        .N_BIT (N_BIT)
    ) u_shreg (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (sh_clear),
        .shift_en_i  (sh_en),
        .shift_bit_i (sh_bit),
        .data_d_o    (sh_data),
        .full_d_o    (sh_full)
    );

    // Load sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            tot_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            word_q  <= '0;
`ifdef PUF_SOC_CHAL_CTRL_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        if (len_ok) begin
                            len_q   <= i_len;
                            tot_q   <= '0;
                            state_q <= ST_SHIFT;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b1;
`ifdef PUF_SOC_CHAL_CTRL_TIMEOUT_EN
                            wd_q    <= '0;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (accept) begin
                        tot_q <= tot_d;
`ifdef PUF_SOC_CHAL_CTRL_TIMEOUT_EN
                        wd_q  <= '0;
`endif
                        if (sh_full) begin
                            state_q <= ST_PUSH;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                            word_q  <= sh_data;
                        end else if (tot_d == len_q) begin
                            state_q <= ST_PAD;
                            ready_q <= 1'b0;
                        end
                    end
`ifdef PUF_SOC_CHAL_CTRL_TIMEOUT_EN
                    else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        wd_q    <= '0;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
`endif
                end
                ST_PAD: begin
                    if (sh_full) begin
                        state_q <= ST_PUSH;
                        valid_q <= 1'b1;
                        word_q  <= sh_data;
                    end
                end
                ST_PUSH: begin
                    if (i_word_ready) begin
                        valid_q <= 1'b0;
                        if (tot_q == len_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SHIFT;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ser_ready  = ready_q;
    assign o_word_valid = valid_q;
    assign o_word_data  = word_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule
